// File: rtl/dualmem_stream_reader_if.sv
// Byte stream handshake between the ring-buffer drain engine and its sink.
interface dualmem_stream_reader_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/dualmem_stream_reader.sv
// Drains a byte ring buffer through BRAM port B into a valid/ready stream,
// hiding the one-cycle read latency behind a 2-entry output buffer.
module dualmem_stream_reader #(
  parameter int rwidth = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [rwidth-1:0] wr_ptr,
  input  logic              flush,
  output logic [rwidth-1:0] addrb,
  output logic              enb,
  output logic              web,
  output logic [7:0]        dinb,
  input  logic [7:0]        doutb,
  dualmem_stream_reader_if.master m,
  output logic [rwidth-1:0] rd_ptr,
  output logic              empty,
  output logic [rwidth-1:0] level
);

  localparam logic [rwidth-1:0] one = rwidth'(1);

  logic [rwidth-1:0] issue_ptr_reg;
  logic [rwidth-1:0] rd_ptr_reg;
  logic              pend_reg;
  logic [1:0]        cnt_reg;
  logic [7:0]        buf0_reg;
  logic [7:0]        buf1_reg;

  logic       pop;
  logic       issue_ok;
  logic [2:0] occ;
  logic [1:0] cnt_after;
  logic [1:0] cnt_next;
  logic [7:0] buf0_next;
  logic [7:0] buf1_next;

  // Credit accounting: bytes buffered plus reads in flight, net of this cycle's pop.
  always_comb begin
    pop       = (cnt_reg != 2'd0) && m.m_ready;
    occ       = {1'b0, cnt_reg} + {2'b00, pend_reg} - {2'b00, pop};
    issue_ok  = (issue_ptr_reg != wr_ptr) && (occ < 3'd2) && !flush;
    cnt_after = cnt_reg - {1'b0, pop};
    buf0_next = pop ? buf1_reg : buf0_reg;
    buf1_next = buf1_reg;
    // The returning byte lands in the first free slot after the pop shift.
    if (pend_reg) begin
      if (cnt_after == 2'd0) buf0_next = doutb;
      else                   buf1_next = doutb;
    end
    cnt_next = cnt_after + {1'b0, pend_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_ptr_reg <= '0;
      rd_ptr_reg    <= '0;
      pend_reg      <= 1'b0;
      cnt_reg       <= 2'd0;
      buf0_reg      <= 8'h00;
      buf1_reg      <= 8'h00;
    end else if (flush) begin
      issue_ptr_reg <= wr_ptr;
      rd_ptr_reg    <= wr_ptr;
      pend_reg      <= 1'b0;
      cnt_reg       <= 2'd0;
    end else begin
      pend_reg <= issue_ok;
      if (issue_ok) issue_ptr_reg <= issue_ptr_reg + one;
      if (pop)      rd_ptr_reg    <= rd_ptr_reg + one;
      cnt_reg  <= cnt_next;
      buf0_reg <= buf0_next;
      buf1_reg <= buf1_next;
    end
  end

  assign addrb     = issue_ptr_reg;
  assign enb       = issue_ok;
  assign web       = 1'b0;
  assign dinb      = 8'h00;
  assign m.m_data  = buf0_reg;
  assign m.m_valid = (cnt_reg != 2'd0);
  assign rd_ptr    = rd_ptr_reg;
  assign empty     = (rd_ptr_reg == wr_ptr);
  assign level     = wr_ptr - rd_ptr_reg;

endmodule

// File: doc/dualmem_stream_reader.md
# dualmem_stream_reader

Ring-buffer drain engine for the byte-wide dual-port BRAM. A producer writes bytes through BRAM port A and publishes its write pointer. This block owns BRAM port B: it reads bytes from its read pointer up to the producer's write pointer and presents them as a valid/ready byte stream (e.g. to a UART TX or console sink). It hides the one-cycle BRAM read latency with a 2-entry output buffer, sustains 1 byte/cycle, and returns its read pointer to the producer for full detection.

## Interface

- `rwidth`, default 13: BRAM address width. Ring size is 2^rwidth bytes.
- `clk`  input  1: single clock, also drives BRAM port B.
- `rst`  input  1: reset, synchronous and active-high.
- `wr_ptr`  input  rwidth: producer write pointer, the next address it will write. Bytes in [rd_ptr, wr_ptr) are valid.
- `flush`  input  1: discard all unread data.
- `addrb`  output  rwidth: BRAM port B address.
- `enb`  output  1: BRAM port B enable (read strobe).
- `web`  output  1: constant 0.
- `dinb`  output  8: constant 0.
- `doutb`  input  8: BRAM port B data; valid the cycle after `enb`.
- `m_data`  output  8: stream byte.
- `m_valid`  output  1: stream valid.
- `m_ready`  input  1: stream ready.
- `rd_ptr`  output  rwidth: address of the oldest byte not yet consumed on the stream.
- `empty`  output  1: `rd_ptr == wr_ptr`.
- `level`  output  rwidth: `wr_ptr - rd_ptr`, mod 2^rwidth.

## Operation

- **Internal state:**
  - `issue_ptr` (rwidth): next address to read.
  - `pend` (1b): a read is in flight.
  - 2-entry FIFO: `buf0`/`buf1` plus `cnt` in 0..2.
  - `rd_ptr` register.
- **Issue condition:** `issue_ok = (issue_ptr != wr_ptr) && (cnt + pend - pop < 2) && !flush`.
  - `pop = m_valid && m_ready`.
  - `enb = issue_ok`, `addrb = issue_ptr`. Both are combinational.
  - On issue, `issue_ptr` increments by 1 mod 2^rwidth.
- **Capture:** when `pend` is 1, `doutb` is written into the FIFO tail that cycle. `pend` takes the value of `issue_ok` each cycle.
- **Pop:** `m_data = buf0`, `m_valid = (cnt != 0)`. On pop, `buf0 <= buf1` (or the captured byte), and `rd_ptr` increments by 1 mod 2^rwidth.
- **Simultaneous push and pop:** `cnt` is unchanged and ordering is preserved. The captured byte goes to the correct slot based on `cnt`.
- **Credit rule:** FIFO occupancy plus in-flight reads never exceeds 2, so no byte is ever dropped.
- **Wrap:** address 2^rwidth-1 is followed by address 0, with no gap or stall.
- **Full ring:** the producer may hold at most 2^rwidth-1 bytes. This block treats `rd_ptr == wr_ptr` only as empty.
- **`flush` == 1:**
  - Next cycle: `issue_ptr <= wr_ptr`, `rd_ptr <= wr_ptr`, `cnt <= 0`, `pend <= 0`.
  - An in-flight byte is discarded.
  - `m_valid` is 0 from the cycle after `flush`. A pop in the `flush` cycle itself is still a legal transfer.
  - `flush` has priority over issue.
- **`wr_ptr` constraint:** `wr_ptr` may move only forward; data at [rd_ptr, wr_ptr) must be stable in the BRAM.
- **Reset values:** `issue_ptr`, `rd_ptr` = 0; `cnt` = 0; `pend` = 0; `m_valid` = 0; `m_data` = 0; `enb` = 0; `empty` = 1 with `wr_ptr` = 0; `level` = `wr_ptr`.
- **Reset mid-operation:** aborts any in-flight read and drops buffered bytes.

## Timing

- **Latency:** `wr_ptr` advances in cycle t (pipeline idle) → `enb` high in cycle t → byte captured at the end of t+1 → `m_valid` high in cycle t+2. Read-to-stream latency is 2 cycles.
- **Throughput:** with `m_ready` held 1, one byte per cycle after the initial 2-cycle latency.
- **Backpressure:** `m_ready` low stops issuing within 1 cycle, at most 2 bytes held. When `m_ready` rises, streaming resumes with no bubble while data remains.
- **`m_valid`/`m_data` stability:** once `m_valid` is 1, `m_valid` and `m_data` are held stable until a pop (except on `flush` or `rst`).
- `rd_ptr`, `empty` and `level` update the cycle after a pop.
- `web` and `dinb` are constant 0 in every cycle.

## Test plan

- **Reset:** assert `rst` 3 cycles with `wr_ptr` = 0 → `m_valid` = 0, `enb` = 0, `rd_ptr` = 0, `empty` = 1, `level` = 0.
- **Basic stream:** preload 0x10..0x1F at addresses 0..15, step `wr_ptr` 0→16 in one cycle, `m_ready` = 1 → `m_valid` rises 2 cycles later; 16 consecutive bytes 0x10..0x1F; `rd_ptr` = 16, `empty` = 1.
- **Backpressure:** same data, toggle `m_ready` randomly → byte order is exact, no loss or duplication, and FIFO occupancy plus in-flight reads ≤ 2 every cycle (assertion).
- **Wrap:** reset to `rd_ptr` = 8190 via flush, with `wr_ptr` = 8190. Write 0xA0..0xA3 at 8190, 8191, 0, 1 and set `wr_ptr` = 2 → stream is 0xA0..0xA3 with no stall cycle; `rd_ptr` = 2.
- **Flush mid-stream:** `wr_ptr` = 100, `m_ready` = 0, wait until 2 bytes are buffered, pulse `flush` → `m_valid` = 0 the next cycle; `rd_ptr` = 100, `level` = 0; no further `enb`.
- **Trickle:** `wr_ptr` increments by 1 every 3 cycles with `m_ready` = 1 → each byte appears exactly 2 cycles after its `wr_ptr` step, and `empty` toggles accordingly.
